// File: rtl/ext_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ext_bus_ctrl
// Purpose  : Multiplexed external bus controller: latched address segments,
//            wait-stated data phase, upper-segment latch caching.
// Revision : 1.0  initial release
// ============================================================================
module ext_bus_ctrl #(
  parameter int BUS_W  = 16,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int WS_W   = 3
) (
  input  logic                                  wb_clk_i,
  input  logic                                  rst_n,
  input  logic                                  req_valid,
  output logic                                  req_ready,
  input  logic                                  req_we,
  input  logic [ADDR_W-1:0]                     req_addr,
  input  logic [DATA_W-1:0]                     req_wdata,
  input  logic [DATA_W/8-1:0]                   req_be,
  output logic                                  rsp_valid,
  output logic [DATA_W-1:0]                     rsp_rdata,
  input  logic [WS_W-1:0]                       wait_states,
  input  logic [1:0]                            strobe_mode,
  output logic [BUS_W-1:0]                      bus_out,
  input  logic [BUS_W-1:0]                      bus_in,
  output logic                                  bus_dir,
  output logic [(ADDR_W+BUS_W-1)/BUS_W-1:0]     le,
  output logic                                  oe_n,
  output logic [BUS_W/8-1:0]                    we_n
);

  localparam int c_n_le  = (ADDR_W + BUS_W - 1) / BUS_W;
  localparam int c_beats = DATA_W / BUS_W;
  localparam int c_bpb   = BUS_W / 8;
  localparam int c_be_w  = DATA_W / 8;
  localparam int c_bw    = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam int c_sw    = $clog2(c_n_le + 1);
  localparam int c_nc    = (c_n_le > 1) ? c_n_le - 1 : 1;
  localparam int c_ext_w = c_n_le * BUS_W;

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_addr = 3'd1;
  localparam logic [2:0] c_st_data = 3'd2;
  localparam logic [2:0] c_st_turn = 3'd3;
  localparam logic [2:0] c_st_resp = 3'd4;

  logic [2:0]            r_state, w_state_nxt;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [c_be_w-1:0]     r_be;
  logic [WS_W-1:0]       r_ws, r_cnt;
  logic [1:0]            r_mode;
  logic [c_bw-1:0]       r_beat;
  logic [c_sw-1:0]       r_lim;
  logic [c_nc*BUS_W-1:0] r_cache;
  logic                  r_cache_vld;
  logic [DATA_W-1:0]     r_rbuf, r_rdata;

  logic [ADDR_W-1:0]     w_beat_addr;
  logic [c_ext_w-1:0]    w_addr_ext;
  logic [c_sw-1:0]       w_seg_sel;
  logic [BUS_W-1:0]      w_seg_val, w_wslice;
  logic [c_bpb-1:0]      w_be_slice, w_we_raw;
  logic [DATA_W-1:0]     w_rbuf_nxt;
  logic [c_bw:0]         w_first, w_next;
  logic                  w_last_beat;

  // Returns {found, index} of the first beat at or after start that needs a
  // bus cycle; writes with all byte enables clear need none.
  function automatic logic [c_bw:0] f_find_beat(input logic we,
                                                input logic [c_be_w-1:0] be,
                                                input int start);
    logic [c_bw:0] res;
    res = '0;
    for (int b = c_beats - 1; b >= 0; b--) begin
      if (b >= start && (!we || (|be[b*c_bpb +: c_bpb]))) begin
        res[c_bw]       = 1'b1;
        res[c_bw-1:0]   = c_bw'(b);
      end
    end
    return res;
  endfunction

  assign w_beat_addr = r_addr + ADDR_W'(r_beat) * ADDR_W'(c_bpb);
  assign w_last_beat = (r_beat == c_bw'(c_beats - 1));
  assign w_first     = f_find_beat(req_we, req_be, 0);
  assign w_next      = f_find_beat(r_we, r_be, int'(r_beat) + 1);

  // Highest upper segment below r_lim that misses the cache, else segment 0.
  always_comb begin
    w_addr_ext = '0;
    w_addr_ext[ADDR_W-1:0] = w_beat_addr;
    w_seg_sel = '0;
    for (int k = 1; k < c_n_le; k++) begin
      if (k < int'(r_lim) &&
          (!r_cache_vld || w_addr_ext[k*BUS_W +: BUS_W] != r_cache[(k-1)*BUS_W +: BUS_W]))
        w_seg_sel = c_sw'(k);
    end
    w_seg_val = '0;
    for (int k = 0; k < c_n_le; k++) begin
      if (w_seg_sel == c_sw'(k)) w_seg_val = w_addr_ext[k*BUS_W +: BUS_W];
    end
  end

  always_comb begin
    w_wslice   = '0;
    w_be_slice = '0;
    w_rbuf_nxt = r_rbuf;
    for (int b = 0; b < c_beats; b++) begin
      if (r_beat == c_bw'(b)) begin
        w_wslice                  = r_wdata[b*BUS_W +: BUS_W];
        w_be_slice                = r_be[b*c_bpb +: c_bpb];
        w_rbuf_nxt[b*BUS_W +: BUS_W] = bus_in;
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (req_valid) w_state_nxt = w_first[c_bw] ? c_st_addr : c_st_resp;
      c_st_addr: if (w_seg_sel == '0) w_state_nxt = c_st_data;
      c_st_data: begin
        if (r_cnt == '0) begin
          if (!r_we) w_state_nxt = w_last_beat ? c_st_resp : c_st_turn;
          else       w_state_nxt = w_next[c_bw] ? c_st_addr : c_st_resp;
        end
      end
      c_st_turn: w_state_nxt = c_st_addr;
      c_st_resp: w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_ws        <= '0;
      r_cnt       <= '0;
      r_mode      <= '0;
      r_beat      <= '0;
      r_lim       <= '0;
      r_cache     <= '0;
      r_cache_vld <= 1'b0;
      r_rbuf      <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_ws    <= wait_states;
            r_mode  <= strobe_mode;
            r_beat  <= w_first[c_bw-1:0];
            r_lim   <= c_sw'(c_n_le);
          end
        end
        c_st_addr: begin
          for (int k = 1; k < c_n_le; k++) begin
            if (w_seg_sel == c_sw'(k)) r_cache[(k-1)*BUS_W +: BUS_W] <= w_seg_val;
          end
          if (w_seg_sel == '0) begin
            r_cache_vld <= 1'b1;
            r_cnt       <= r_ws;
          end else begin
            r_lim <= w_seg_sel;
          end
        end
        c_st_data: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_lim <= c_sw'(c_n_le);
            if (!r_we) begin
              r_rbuf <= w_rbuf_nxt;
              if (w_last_beat) r_rdata <= w_rbuf_nxt;
              else             r_beat  <= r_beat + 1'b1;
            end else begin
              r_beat <= w_next[c_bw-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = (r_state == c_st_idle);
    rsp_valid = (r_state == c_st_resp);
    rsp_rdata = r_rdata;
    bus_out   = '0;
    bus_dir   = 1'b1;
    le        = '0;
    oe_n      = 1'b1;
    w_we_raw  = '1;
    case (r_state)
      c_st_addr: begin
        bus_dir = 1'b0;
        bus_out = w_seg_val;
        for (int k = 0; k < c_n_le; k++) le[k] = (w_seg_sel == c_sw'(k));
      end
      c_st_data: begin
        if (r_we) begin
          bus_dir  = 1'b0;
          bus_out  = w_wslice;
          w_we_raw = ~w_be_slice;
        end else begin
          oe_n = 1'b0;
        end
      end
      default: ;
    endcase
    // Clock-gated strobe shaping keeps we_n inside one half of the cycle.
    case (r_mode)
      2'd1:    we_n = w_we_raw | {c_bpb{wb_clk_i}};
      2'd2:    we_n = w_we_raw | {c_bpb{~wb_clk_i}};
      default: we_n = w_we_raw;
    endcase
  end

endmodule
`default_nettype wire
